// File: rtl/uart_boot_loader.sv
// uart_boot_loader
//   Receives a program image over a raw UART pin and writes it word by word into
//   the SoC instruction memory. The CPU is held in reset until a checksum-valid
//   image has landed, or until loading is bypassed with boot_en=0.
//   Frame: SYNC_BYTE, len_lo, len_hi (word count), 4*len data bytes (LE words),
//   one XOR checksum byte over the data bytes only.
// Ports
//   clk, reset_n   system clock, async active-low reset
//   boot_en        1 = wait for image, 0 = release CPU straight from IDLE
//   rx_i           raw serial input, idle high, asynchronous to clk
//   mem_we/addr/wdata  one-cycle instruction memory write port
//   cpu_reset_n    core reset, high only in DONE/RUN
//   boot_done      image verified (sticky until reset)
//   boot_err       framing/length/checksum error (cleared by the next SYNC_BYTE)
module uart_boot_loader #(
  parameter int          CLK_FREQ_HZ = 100_000_000,
  parameter int          BAUD        = 115200,
  parameter int          ADDR_WIDTH  = 10,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  boot_en,
  input  logic                  rx_i,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_reset_n,
  output logic                  boot_done,
  output logic                  boot_err
);
  localparam int          CPB     = CLK_FREQ_HZ / BAUD;
  localparam int          HALF    = CPB / 2;
  localparam int          CW      = $clog2(CPB + 1);
  localparam logic [16:0] MAX_LEN = 17'(1 << ADDR_WIDTH);

  // ---------------- serial receiver ----------------
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  rx_state_t   rx_st, rx_nxt;
  logic        rx_s1, rx_s, rx_prev;
  logic [CW-1:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  rx_byte;
  logic        rx_valid, frame_err;
  logic        tick;

  assign tick = (rx_st == RX_START && cnt == CW'(HALF - 1)) ||
                ((rx_st == RX_DATA || rx_st == RX_STOP) && cnt == CW'(CPB - 1));

  always_comb begin
    rx_nxt = rx_st;
    case (rx_st)
      // edge detect, not level: a framing error leaves the line low, and we
      // must not treat that as a fresh start bit
      RX_IDLE:  if (rx_prev && !rx_s) rx_nxt = RX_START;
      RX_START: if (tick) rx_nxt = rx_s ? RX_IDLE : RX_DATA;  // high at mid-start = glitch
      RX_DATA:  if (tick && bit_idx == 3'd7) rx_nxt = RX_STOP;
      RX_STOP:  if (tick) rx_nxt = RX_IDLE;
      default:  rx_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_s1 <= 1'b1; rx_s <= 1'b1; rx_prev <= 1'b1;
      rx_st <= RX_IDLE; cnt <= '0; bit_idx <= '0; rx_byte <= '0;
      rx_valid <= 1'b0; frame_err <= 1'b0;
    end else begin
      rx_s1     <= rx_i;
      rx_s      <= rx_s1;
      rx_prev   <= rx_s;
      rx_st     <= rx_nxt;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      cnt       <= (rx_st == RX_IDLE || tick) ? '0 : cnt + 1'b1;
      if (rx_st == RX_START) bit_idx <= '0;
      if (tick && rx_st == RX_DATA) begin
        rx_byte <= {rx_s, rx_byte[7:1]};
        bit_idx <= bit_idx + 1'b1;
      end
      if (tick && rx_st == RX_STOP) begin
        rx_valid  <= rx_s;
        frame_err <= !rx_s;
      end
    end
  end

  // ---------------- loader FSM ----------------
  typedef enum logic [2:0] {S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_DONE, S_RUN, S_ERR} state_t;
  state_t            st, st_nxt;
  logic [15:0]       len;
  logic [ADDR_WIDTH:0] word_cnt, word_cnt_inc;
  logic [1:0]        byte_idx;
  logic [7:0]        csum;
  logic [31:0]       wbuf;
  logic [16:0]       len_new;

  assign word_cnt_inc = word_cnt + 1'b1;
  assign len_new      = {1'b0, rx_byte, len[7:0]};

  always_comb begin
    st_nxt = st;
    case (st)
      S_IDLE:   if (!boot_en) st_nxt = S_RUN;
                else if (frame_err) st_nxt = S_ERR;
                else if (rx_valid && rx_byte == SYNC_BYTE) st_nxt = S_LEN_LO;
      S_LEN_LO: if (frame_err) st_nxt = S_ERR;
                else if (rx_valid) st_nxt = S_LEN_HI;
      S_LEN_HI: if (frame_err) st_nxt = S_ERR;
                else if (rx_valid) begin
                  if (len_new > MAX_LEN)  st_nxt = S_ERR;
                  else if (len_new == '0) st_nxt = S_CSUM;
                  else                    st_nxt = S_DATA;
                end
      S_DATA:   if (frame_err) st_nxt = S_ERR;
                else if (rx_valid && byte_idx == 2'd3 &&
                         17'(word_cnt_inc) == {1'b0, len}) st_nxt = S_CSUM;
      S_CSUM:   if (frame_err) st_nxt = S_ERR;
                else if (rx_valid) st_nxt = (rx_byte == csum) ? S_DONE : S_ERR;
      S_ERR:    if (rx_valid && rx_byte == SYNC_BYTE) st_nxt = S_LEN_LO;
      default:  st_nxt = st;  // DONE/RUN are terminal
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st <= S_IDLE; len <= '0; word_cnt <= '0; byte_idx <= '0; csum <= '0; wbuf <= '0;
      mem_we <= 1'b0; mem_addr <= '0; mem_wdata <= '0;
      cpu_reset_n <= 1'b0; boot_done <= 1'b0; boot_err <= 1'b0;
    end else begin
      st          <= st_nxt;
      mem_we      <= 1'b0;
      cpu_reset_n <= (st == S_DONE || st == S_RUN);
      boot_done   <= (st == S_DONE);
      boot_err    <= (st == S_ERR);
      if (rx_valid) begin
        case (st)
          S_LEN_LO: len[7:0] <= rx_byte;
          S_LEN_HI: begin
            len[15:8] <= rx_byte;
            word_cnt  <= '0;
            byte_idx  <= '0;
            csum      <= '0;
          end
          S_DATA: begin
            wbuf[{byte_idx, 3'b000} +: 8] <= rx_byte;
            csum     <= csum ^ rx_byte;
            byte_idx <= byte_idx + 1'b1;
            if (byte_idx == 2'd3) begin
              mem_we    <= 1'b1;
              mem_addr  <= word_cnt[ADDR_WIDTH-1:0];
              mem_wdata <= {rx_byte, wbuf[23:0]};
              word_cnt  <= word_cnt_inc;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_boot_loader.sv
// Self-checking bench for uart_boot_loader. Runs the DUT at 16 clocks per bit;
// expected memory writes go into a scoreboard queue as frames are sent and are
// popped by a monitor whenever mem_we fires.
module tb_uart_boot_loader;
  localparam int CPB = 16;
  localparam int AW  = 10;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          boot_en = 1'b1;
  logic          rx_i = 1'b1;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          cpu_reset_n, boot_done, boot_err;

  typedef struct { logic [AW-1:0] addr; logic [31:0] data; } wr_t;
  wr_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  uart_boot_loader #(.CLK_FREQ_HZ(1_600_000), .BAUD(100_000), .ADDR_WIDTH(AW), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .reset_n(reset_n), .boot_en(boot_en), .rx_i(rx_i),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_reset_n(cpu_reset_n), .boot_done(boot_done), .boot_err(boot_err));

  always #5 clk = ~clk;

  // scoreboard consumer
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_t e;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write addr=%0h data=%h", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        if (mem_addr !== e.addr || mem_wdata !== e.data) begin
          n_fail++;
          $display("FAIL write got addr=%0h data=%h want addr=%0h data=%h", mem_addr, mem_wdata, e.addr, e.data);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit stop = 1'b1);
    rx_i = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      repeat (CPB) @(posedge clk);
    end
    rx_i = stop;
    repeat (CPB) @(posedge clk);
    rx_i = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  function automatic logic [7:0] xor_word(input logic [31:0] w);
    return w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
  endfunction

  // two-word frame; csum_flip corrupts the checksum byte
  task automatic send_frame(input logic [31:0] w0, input logic [31:0] w1, input logic [7:0] csum_flip);
    wr_t e;
    e.addr = '0;      e.data = w0; exp_q.push_back(e);
    e.addr = AW'(1);  e.data = w1; exp_q.push_back(e);
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
    for (int i = 0; i < 4; i++) send_byte(w0[8*i +: 8]);
    for (int i = 0; i < 4; i++) send_byte(w1[8*i +: 8]);
    send_byte(xor_word(w0) ^ xor_word(w1) ^ csum_flip);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic en);
    boot_en = en;
    rx_i    = 1'b1;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic check_flags(input string name, input logic done, input logic err, input logic crn);
    n_tests++;
    if (boot_done !== done || boot_err !== err || cpu_reset_n !== crn) begin
      n_fail++;
      $display("FAIL %s got done/err/crn=%b%b%b want %b%b%b", name, boot_done, boot_err, cpu_reset_n, done, err, crn);
    end
  endtask

  task automatic check_drained(input string name);
    n_tests++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL %s missing_writes got %0d pending want 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    #1;
    n_tests++;
    if ({mem_we, mem_addr, mem_wdata, cpu_reset_n, boot_done, boot_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got we=%b addr=%0h data=%h crn=%b done=%b err=%b want all 0",
               mem_we, mem_addr, mem_wdata, cpu_reset_n, boot_done, boot_err);
    end
  endtask

  task automatic test_bypass;
    do_reset(1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_flags("bypass", 1'b0, 1'b0, 1'b1);
    repeat (20) @(posedge clk);
  endtask

  task automatic test_good_frame;
    do_reset(1'b1);
    send_frame(32'h12345678, 32'hDEADBEEF, 8'h00);
    check_flags("good_frame", 1'b1, 1'b0, 1'b1);
    check_drained("good_frame");
  endtask

  task automatic test_bad_csum;
    do_reset(1'b1);
    send_frame(32'h12345678, 32'hDEADBEEF, 8'h01);
    check_flags("bad_csum", 1'b0, 1'b1, 1'b0);
    check_drained("bad_csum");
    send_frame(32'hCAFEF00D, 32'h0BADC0DE, 8'h00);
    check_flags("csum_retry", 1'b1, 1'b0, 1'b1);
    check_drained("csum_retry");
  endtask

  task automatic test_length;
    do_reset(1'b1);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h04);
    repeat (3) @(posedge clk);
    #1;
    check_flags("len_too_big", 1'b0, 1'b1, 1'b0);
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    repeat (3) @(posedge clk);
    #1;
    check_flags("len_zero", 1'b1, 1'b0, 1'b1);
    check_drained("length");
  endtask

  task automatic test_framing;
    do_reset(1'b1);
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h78); send_byte(8'h56);
    send_byte(8'h34, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_flags("framing", 1'b0, 1'b1, 1'b0);
    check_drained("framing");
    // short glitch in IDLE must not start a byte
    do_reset(1'b1);
    repeat (5) @(posedge clk);
    rx_i = 1'b0;
    #50;
    rx_i = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check_flags("glitch", 1'b0, 1'b0, 1'b0);
    send_frame(32'h01020304, 32'hA0B0C0D0, 8'h00);
    check_flags("after_glitch", 1'b1, 1'b0, 1'b1);
    check_drained("after_glitch");
  endtask

  task automatic test_reset_mid_load;
    do_reset(1'b1);
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    reset_n = 1'b0;
    #1;
    n_tests++;
    if ({mem_we, mem_addr, mem_wdata, cpu_reset_n, boot_done, boot_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid got we=%b addr=%0h crn=%b done=%b err=%b want all 0",
               mem_we, mem_addr, cpu_reset_n, boot_done, boot_err);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h13);  // garbage before sync
    send_frame(32'h89ABCDEF, 32'h76543210, 8'h00);
    check_flags("reload", 1'b1, 1'b0, 1'b1);
    check_drained("reload");
  endtask

  initial begin
    test_reset;
    test_bypass;
    test_good_frame;
    test_bad_csum;
    test_length;
    test_framing;
    test_reset_mid_load;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
